if_fetch_queue: RTL and testbench

//  Instruction-fetch stage upstream of the memory controller: holds the PC, issues one 4-byte fetch
//  at a time on the IF request port, and buffers returned words with their PC in a FIFO for decode.

---
 rtl/if_fetch_queue.sv | 199 +++++++++++++++++++
 tb/tb_if_fetch_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage in front of the memory controller.
//   Holds the PC and issues one 4-byte fetch at a time. Returned words are
//   queued with their PC for the decoder. JAL is predicted taken by redirecting
//   the PC statically. A backend redirect flushes the queue and any fetch in flight.
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (global enable)
//   if_read_or_not / intru_addr          : fetch request and address to mem_ctrl
//   if_load_done / mem_ctrl_instru_to_if : returned word strobe and data
//   jump_flag / jump_pc                  : backend redirect
//   inst_valid / inst / inst_pc / inst_pred_taken / inst_ready : queue head to decode
module if_fetch_queue #(
  parameter int unsigned IQ_DEPTH    = 8,
  parameter int unsigned IQ_ADDR_LEN = 3,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if_read_or_not,
  output logic [31:0] intru_addr,
  input  logic        if_load_done,
  input  logic [31:0] mem_ctrl_instru_to_if,
  input  logic        jump_flag,
  input  logic [31:0] jump_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_pred_taken,
  input  logic        inst_ready
);

  localparam int unsigned CNT_W = IQ_ADDR_LEN + 1;
  localparam int unsigned PTR_W = IQ_ADDR_LEN;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               drop_q, drop_d;
  logic               req_q, req_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        inst_pc_q, inst_pc_d;
  logic               pred_q, pred_d;

  // Queue storage; contents only matter where count says so, hence no reset.
  logic [31:0]        word_mem_q [IQ_DEPTH];
  logic [31:0]        pc_mem_q   [IQ_DEPTH];
  logic               pred_mem_q [IQ_DEPTH];

  logic               push_c;
  logic               pop_c;
  logic               flush_c;
  logic               is_jal_c;
  logic [31:0]        jal_imm_c;
  logic [31:0]        next_pc_c;
  logic [CNT_W-1:0]   remain_c;

  // Static next-PC: JAL is predicted taken, everything else falls through.
  always_comb begin
    is_jal_c  = (mem_ctrl_instru_to_if[6:0] == 7'b1101111);
    jal_imm_c = {{11{mem_ctrl_instru_to_if[31]}}, mem_ctrl_instru_to_if[31],
                 mem_ctrl_instru_to_if[19:12], mem_ctrl_instru_to_if[20],
                 mem_ctrl_instru_to_if[30:21], 1'b0};
    next_pc_c = is_jal_c ? (pc_q + jal_imm_c) : (pc_q + 32'd4);
  end

  // Fetch FSM next-state and request control.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    req_d   = req_q;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    flush_c = 1'b0;

    if (jump_flag) begin
      // A fetch still outstanding will return a word for the old address.
      flush_c = 1'b1;
      pc_d    = jump_pc;
      req_d   = 1'b0;
      state_d = S_IDLE;
      drop_d  = (state_q == S_WAIT);
    end else begin
      pop_c = valid_q && inst_ready;
      if (if_load_done && drop_q) begin
        drop_d = 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          // Leave a free slot for the word that this fetch will bring back.
          if (count_q < CNT_W'(IQ_DEPTH - 1)) begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            drop_d  = 1'b0;
          end
        end
        S_WAIT: begin
          if (if_load_done && !drop_q && (count_q != CNT_W'(IQ_DEPTH))) begin
            push_c  = 1'b1;
            pc_d    = next_pc_c;
            req_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Queue pointers, occupancy and the registered head view.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    remain_c  = count_q - CNT_W'(pop_c);
    valid_d   = 1'b0;
    inst_d    = 32'h0;
    inst_pc_d = 32'h0;
    pred_d    = 1'b0;

    if (flush_c) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_c);
      tail_d  = tail_q + PTR_W'(push_c);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    if (count_d != '0) begin
      valid_d = 1'b1;
      // Pushing into an otherwise empty queue: the new word becomes the head.
      if (remain_c == '0) begin
        inst_d    = mem_ctrl_instru_to_if;
        inst_pc_d = pc_q;
        pred_d    = is_jal_c;
      end else begin
        inst_d    = word_mem_q[head_d];
        inst_pc_d = pc_mem_q[head_d];
        pred_d    = pred_mem_q[head_d];
      end
    end
  end

  // State and output registers; reset wins, rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      req_q     <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      pred_q    <= 1'b0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      req_q     <= req_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      pred_q    <= pred_d;
    end
  end

  // Queue entry write at the tail.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && push_c) begin
      word_mem_q[tail_q] <= mem_ctrl_instru_to_if;
      pc_mem_q[tail_q]   <= pc_q;
      pred_mem_q[tail_q] <= is_jal_c;
    end
  end

  assign if_read_or_not  = req_q;
  assign intru_addr      = pc_q;
  assign inst_valid      = valid_q;
  assign inst            = inst_q;
  assign inst_pc         = inst_pc_q;
  assign inst_pred_taken = pred_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;

  localparam int unsigned IQ_DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_read_or_not;
  logic [31:0] intru_addr;
  logic        if_load_done;
  logic [31:0] mem_ctrl_instru_to_if;
  logic        jump_flag;
  logic [31:0] jump_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pred_taken;
  logic        inst_ready;

  if_fetch_queue #(.IQ_DEPTH(IQ_DEPTH), .IQ_ADDR_LEN(3), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_read_or_not(if_read_or_not), .intru_addr(intru_addr),
    .if_load_done(if_load_done), .mem_ctrl_instru_to_if(mem_ctrl_instru_to_if),
    .jump_flag(jump_flag), .jump_pc(jump_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_pred_taken(inst_pred_taken), .inst_ready(inst_ready)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_req;
  bit          m_wait;
  bit          m_drop;

  // Memory responder state
  int          lat;
  bit          stale_pending;
  int          rst_hold;

  int          n_checks;
  int          n_pass;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Program image: a fixed prologue, then pseudo-random ALU ops and JALs.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (a < 32'h20) return (a == 32'h10) ? 32'h0100006F : 32'h00000013;
    h = a * 32'h9E3779B1;
    h = h ^ (h >> 15);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    if (h[2:0] == 3'd0) return {h[31:7], 7'b1101111};
    return {h[31:7], 7'b0010011};
  endfunction

  // JAL target offset built arithmetically from the immediate fields.
  function automatic logic [31:0] model_next(input logic [31:0] w, input logic [31:0] pc);
    int signed imm;
    if (w[6:0] != 7'b1101111) return pc + 32'd4;
    imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096;
    if (w[31]) imm = imm - 1048576;
    return pc + 32'(imm);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_req  = 1'b0;
    m_wait = 1'b0;
    m_drop = 1'b0;
  endtask

  // Advance the model by the clock edge about to happen, using current inputs.
  task automatic model_step();
    int   sz0;
    bit   was_wait;
    ent_t e;
    if (!rst_in) begin
      model_reset();
      return;
    end
    if (!rdy_in) return;
    if (jump_flag) begin
      mq.delete();
      m_drop = m_wait;
      m_pc   = jump_pc;
      m_req  = 1'b0;
      m_wait = 1'b0;
      return;
    end
    sz0      = mq.size();
    was_wait = m_wait;
    if (inst_ready && sz0 != 0) void'(mq.pop_front());
    if (if_load_done && m_drop) begin
      m_drop = 1'b0;
    end else if (was_wait && if_load_done && sz0 < IQ_DEPTH) begin
      e.word = mem_ctrl_instru_to_if;
      e.pc   = m_pc;
      e.pred = (mem_ctrl_instru_to_if[6:0] == 7'b1101111);
      mq.push_back(e);
      m_pc   = model_next(mem_ctrl_instru_to_if, m_pc);
      m_req  = 1'b0;
      m_wait = 1'b0;
    end
    if (!was_wait && sz0 < IQ_DEPTH - 1) begin
      m_wait = 1'b1;
      m_req  = 1'b1;
      m_drop = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    check_eq("req", 32'(if_read_or_not), 32'(m_req));
    check_eq("addr", intru_addr, m_pc);
    check_eq("valid", 32'(inst_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("inst", inst, mq[0].word);
      check_eq("inst_pc", inst_pc, mq[0].pc);
      check_eq("pred", 32'(inst_pred_taken), 32'(mq[0].pred));
    end
  endtask

  // One cycle per iteration: check at negedge, drive inputs, advance model.
  task automatic run_cycles(input int n, input int p_ready, input int p_jump,
                            input int p_stall, input int p_stale);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      compare_outputs();
      if (rst_hold > 0) begin
        rst_in = 1'b0;
        rst_hold--;
      end else begin
        rst_in = 1'b1;
      end
      rdy_in     = ($urandom_range(0, 99) >= p_stall);
      inst_ready = ($urandom_range(0, 99) < p_ready);
      jump_flag  = ($urandom_range(0, 999) < p_jump);
      jump_pc    = 32'($urandom_range(0, 4095)) << 2;
      if_load_done          = 1'b0;
      mem_ctrl_instru_to_if = $urandom;
      if (stale_pending) begin
        if_load_done  = 1'b1;
        stale_pending = 1'b0;
      end else if (m_wait) begin
        if (lat == 0) begin
          if_load_done          = 1'b1;
          mem_ctrl_instru_to_if = mem_word(m_pc);
          lat                   = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end
      if (jump_flag && m_wait && rst_in && rdy_in && ($urandom_range(0, 99) < p_stale))
        stale_pending = 1'b1;
      model_step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    lat      = 0;
    stale_pending = 1'b0;
    rst_hold = 0;
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    if_load_done = 1'b0;
    mem_ctrl_instru_to_if = 32'h0;
    jump_flag  = 1'b0;
    jump_pc    = 32'h0;
    inst_ready = 1'b0;
    model_reset();

    // Reset held two cycles
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check_eq("rst_addr", intru_addr, 32'h0);
    check_eq("rst_req", 32'(if_read_or_not), 32'h0);
    check_eq("rst_valid", 32'(inst_valid), 32'h0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_pred", 32'(inst_pred_taken), 32'h0);
    rst_in = 1'b1;
    model_step();

    // Prologue with decoder stalled: sequential fetch, JAL at 0x10, queue fills to 7
    run_cycles(80, 0, 0, 0, 0);
    @(negedge clk_in);
    check_eq("full_req", 32'(if_read_or_not), 32'h0);
    check_eq("full_valid", 32'(inst_valid), 32'h1);
    check_eq("full_head_pc", inst_pc, 32'h0);
    model_step();

    // Drain partly so fetch resumes
    run_cycles(40, 30, 0, 0, 0);
    // Mixed random traffic
    run_cycles(2000, 60, 20, 10, 70);
    // Mid-run reset
    rst_hold = 2;
    run_cycles(300, 50, 20, 5, 70);
    // Redirect-heavy phase with stale returns
    run_cycles(1500, 70, 120, 5, 90);
    // Stall-heavy phase
    run_cycles(800, 20, 10, 40, 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
